// File: rtl/uart_cmd_sequencer.sv
// Packet parser behind a UART receiver. It frames SYNC/ADDR/LEN/payload/CSUM, buffers the payload,
// checks the checksum and replays the payload as a burst of register writes.
module uart_cmd_sequencer #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 52090,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       busy,
  output logic       pkt_ok,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_WRITE
  } state_e;

  // state_q is the debug view of the parser; it is left un-renamed so checkers can bind to it.
  state_e        state_q, state_d;
  logic [7:0]    base_q, base_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          err_csum_q, err_csum_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic          pay_we;
  logic [7:0]    idx_nxt;

  logic [7:0] pay_q [0:(1<<IW)-1];

  assign idx_nxt = idx_q + 8'd1;

  // Write port: a write is offered while wr_en is high and completes on the first rising edge
  // where wr_ready is also high; wr_addr/wr_data never change while an offer is pending.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    tmo_d         = tmo_q;
    wr_en_d       = wr_en_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pkt_ok_d      = 1'b0;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    pay_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid) begin
          base_d  = rx_data;
          sum_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || ({1'b0, rx_data} > MAX_LEN_W)) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data;
            sum_d   = sum_q + rx_data;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          pay_we = 1'b1;
          sum_d  = sum_q + rx_data;
          idx_d  = idx_nxt;
          if (idx_nxt == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d   = S_WRITE;
            idx_d     = 8'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = pay_q[0];
          end else begin
            err_csum_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (rx_valid) err_overrun_d = 1'b1;
        if (wr_en_q && wr_ready) begin
          idx_d = idx_nxt;
          if (idx_nxt == len_q) begin
            wr_en_d  = 1'b0;
            pkt_ok_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            wr_addr_d = base_q + idx_nxt;
            wr_data_d = pay_q[idx_nxt[IW-1:0]];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog; an arriving byte always beats expiry in the same cycle.
    if ((state_q == S_ADDR) || (state_q == S_LEN) ||
        (state_q == S_PAYLOAD) || (state_q == S_CSUM)) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d         = '0;
        err_timeout_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_q        <= 8'd0;
      len_q         <= 8'd0;
      idx_q         <= 8'd0;
      sum_q         <= 8'd0;
      tmo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 8'd0;
      wr_data_q     <= 8'd0;
      pkt_ok_q      <= 1'b0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      tmo_q         <= tmo_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pkt_ok_q      <= pkt_ok_d;
      err_csum_q    <= err_csum_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Payload storage carries no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (pay_we) pay_q[idx_q[IW-1:0]] <= rx_data;
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != S_IDLE);
  assign pkt_ok      = pkt_ok_q;
  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule
